// File: rtl/vga_sprite_scheduler_pkg.sv
// Shared definitions for the VGA sprite scheduler: screen bounds,
// descriptor field layout, slot indices and FSM state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam int N_SLOTS = 3;
    localparam int DESC_W  = 64;

    // Descriptor layout: {x, y, w, h}, 16 bits each
    localparam int X_MSB = 63;
    localparam int X_LSB = 48;
    localparam int Y_MSB = 47;
    localparam int Y_LSB = 32;
    localparam int W_MSB = 31;
    localparam int W_LSB = 16;
    localparam int H_MSB = 15;
    localparam int H_LSB = 0;

    localparam int SLOT_P1    = 0;
    localparam int SLOT_P2    = 1;
    localparam int SLOT_STAGE = 2;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_COMMIT = 1'b1
    } sched_state_e;

    // Index of the set bit in a one-hot 3-bit grant vector
    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/vga_sprite_scheduler_if.sv
// Write-request bus between the game-logic writers and the sprite scheduler.
// The game logic is the master; the scheduler answers with one-cycle acks.
interface vga_sprite_scheduler_if;
    import vga_pkg::*;

    logic [N_SLOTS-1:0]        req_i;
    logic [N_SLOTS*DESC_W-1:0] desc_i;
    logic [N_SLOTS-1:0]        ack_o;

    modport master (
        output req_i,
        output desc_i,
        input  ack_o
    );

    modport slave (
        input  req_i,
        input  desc_i,
        output ack_o
    );

endinterface

// File: rtl/vga_sprite_scheduler_arb.sv
// Three-way round-robin arbiter. Purely combinational: the caller keeps the
// index of the last granted slot and search starts at the slot after it.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    logic       found;
    logic [1:0] idx;

    // Scan slots last+1, last+2, last+3 (mod 3) and grant the first requester
    always_comb begin
        gnt   = 3'b000;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(last) + k) % 3);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_sprite_scheduler.sv
// Sprite descriptor scheduler: arbitrates game-logic writes into a shadow
// register file and copies the shadows to the live VGA descriptors in a
// single commit cycle that follows each falling edge of vertical sync.
module vga_sprite_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST_n,
    input  logic                     iVS,
    vga_sprite_scheduler_if.slave    bus,
    output logic [DESC_W-1:0]        p1VGA,
    output logic [DESC_W-1:0]        p2VGA,
    output logic [DESC_W-1:0]        stageVGA,
    output logic [N_SLOTS-1:0]       dirty_o,
    output logic                     frame_tick_o,
    output logic [FCNT_W-1:0]        frame_cnt_o,
    output logic [N_SLOTS-1:0]       err_o
);

    sched_state_e       state_reg;
    sched_state_e       state_next;
    logic [1:0]         ptr_reg;
    logic               vs_q;
    logic [FCNT_W-1:0]  fcnt_reg;
    logic [N_SLOTS-1:0] gnt;
    logic [N_SLOTS-1:0] ack;
    logic [N_SLOTS-1:0] valid;
    logic               frame_start;

    assign frame_start = vs_q & ~iVS;

    rr_arbiter3 u_arb (
        .req  (bus.req_i),
        .last (ptr_reg),
        .gnt  (gnt)
    );

    // Grants are suppressed during the commit cycle
    assign ack          = (state_reg == ST_ARB) ? gnt : '0;
    assign bus.ack_o    = ack;
    assign frame_tick_o = (state_reg == ST_COMMIT);
    assign frame_cnt_o  = fcnt_reg;

    // Next-state logic: a frame start in ARB schedules one commit cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:    if (frame_start) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_ARB;
            default:   state_next = ST_ARB;
        endcase
    end

    // State, vsync delay, round-robin pointer and frame counter
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg <= ST_ARB;
            ptr_reg   <= 2'd2;      // slot 0 searched first after reset
            vs_q      <= 1'b1;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            vs_q      <= iVS;
            if (|ack) ptr_reg <= onehot3_to_idx(ack);
            if (state_reg == ST_COMMIT) fcnt_reg <= fcnt_reg + FCNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            logic [DESC_W-1:0] desc_in;
            logic [DESC_W-1:0] shadow_reg;
            logic [DESC_W-1:0] live_reg;
            logic              dirty_reg;
            logic              err_reg;
            logic [16:0]       x_end;
            logic [16:0]       y_end;

            assign desc_in = bus.desc_i[DESC_W*gi +: DESC_W];

            // Right/bottom edges kept 17 bits wide so large x or y cannot wrap into range
            assign x_end = {1'b0, desc_in[X_MSB:X_LSB]} + {1'b0, desc_in[W_MSB:W_LSB]};
            assign y_end = {1'b0, desc_in[Y_MSB:Y_LSB]} + {1'b0, desc_in[H_MSB:H_LSB]};

            assign valid[gi] = (desc_in[W_MSB:W_LSB] != '0) &&
                               (desc_in[H_MSB:H_LSB] != '0) &&
                               (x_end <= 17'(H_ACTIVE))   &&
                               (y_end <= 17'(V_ACTIVE));

            // Shadow write on grant, live update on commit, sticky reject flag
            always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    shadow_reg <= '0;
                    live_reg   <= '0;
                    dirty_reg  <= 1'b0;
                    err_reg    <= 1'b0;
                end else if (state_reg == ST_COMMIT) begin
                    live_reg  <= shadow_reg;
                    dirty_reg <= 1'b0;
                end else if (ack[gi]) begin
                    if (valid[gi]) begin
                        shadow_reg <= desc_in;
                        dirty_reg  <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
            end

            assign dirty_o[gi] = dirty_reg;
            assign err_o[gi]   = err_reg;
        end
    endgenerate

    assign p1VGA    = g_slot[SLOT_P1].live_reg;
    assign p2VGA    = g_slot[SLOT_P2].live_reg;
    assign stageVGA = g_slot[SLOT_STAGE].live_reg;

endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// Self-checking bench for vga_sprite_scheduler. Expected acks and expected
// committed descriptors are queued when stimulus is driven and compared when
// the DUT produces them. A second instance with a 4-bit frame counter covers
// counter wrap in a short run.
module tb_vga_sprite_scheduler;
    import vga_pkg::*;

    typedef struct packed {
        logic [63:0] p1;
        logic [63:0] p2;
        logic [63:0] st;
    } live_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs    = 1'b1;
    logic [63:0] p1, p2, st, p1_s, p2_s, st_s;
    logic [2:0]  dirty, err, dirty_s, err_s;
    logic        tick, tick_s;
    logic [15:0] fcnt;
    logic [3:0]  fcnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0]  ack_q[$];
    live_t       live_q[$];
    logic [63:0] exp_shadow [3];
    live_t       committed;

    vga_sprite_scheduler_if bus();
    vga_sprite_scheduler_if bus_s();

    vga_sprite_scheduler #(.FCNT_W(16)) dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iVS          (vs),
        .bus          (bus),
        .p1VGA        (p1),
        .p2VGA        (p2),
        .stageVGA     (st),
        .dirty_o      (dirty),
        .frame_tick_o (tick),
        .frame_cnt_o  (fcnt),
        .err_o        (err)
    );

    vga_sprite_scheduler #(.FCNT_W(4)) dut_small (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iVS          (vs),
        .bus          (bus_s),
        .p1VGA        (p1_s),
        .p2VGA        (p2_s),
        .stageVGA     (st_s),
        .dirty_o      (dirty_s),
        .frame_tick_o (tick_s),
        .frame_cnt_o  (fcnt_s),
        .err_o        (err_s)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int x, input int y, input int w, input int h);
        return {16'(x), 16'(y), 16'(w), 16'(h)};
    endfunction

    function automatic live_t shadow_snapshot();
        live_t v;
        v.p1 = exp_shadow[0];
        v.p2 = exp_shadow[1];
        v.st = exp_shadow[2];
        return v;
    endfunction

    task automatic tick_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int slot, input logic [63:0] d);
        bus.desc_i[64*slot +: 64] = d;
    endtask

    // Falling vsync edge, commit cycle, then vsync high for one cycle
    task automatic do_frame();
        vs = 1'b0;
        tick_cyc();
        tick_cyc();
        vs = 1'b1;
        tick_cyc();
    endtask

    task automatic test_reset();
        int ticks;
        rst_n = 1'b0;
        vs = 1'b1;
        bus.req_i = '0;
        bus.desc_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({p1, p2, st} !== 192'd0) $display("FAIL reset_live: got %h want 0", {p1, p2, st});
        else n_pass++;
        n_checks++;
        if ({dirty, err, bus.ack_o, tick} !== 10'd0)
            $display("FAIL reset_flags: dirty=%b err=%b ack=%b tick=%b want all 0", dirty, err, bus.ack_o, tick);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            vs = (i < 10);
            @(negedge clk);
            ticks += int'(tick);
            n_checks++;
            if (tick !== (i == 11)) $display("FAIL reset_tick[%0d]: got %b want %b", i, tick, (i == 11));
            else n_pass++;
            n_checks++;
            if ({p1, p2, st, dirty, err, bus.ack_o, fcnt} !== '0)
                $display("FAIL reset_quiet[%0d]: live=%h dirty=%b err=%b fcnt=%0d want 0", i, {p1, p2, st}, dirty, err, fcnt);
            else n_pass++;
            tick_cyc();
        end
        vs = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fcnt !== 16'd1) $display("FAIL reset_fcnt: got %0d want 1", fcnt);
        else n_pass++;
        n_checks++;
        if (ticks != 1) $display("FAIL reset_tick_count: got %0d want 1", ticks);
        else n_pass++;
        $display("txn reset: first commit, frame_cnt=%0d", fcnt);
        tick_cyc();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack;
        live_t      exp_live;
        ack_q.push_back(3'b001);
        ack_q.push_back(3'b010);
        ack_q.push_back(3'b100);
        ack_q.push_back(3'b001);
        bus.req_i = 3'b111;
        for (int i = 0; i < 4; i++) begin
            set_desc(0, mk(10 * i, 20, 30, 40));
            set_desc(1, mk(100 + i, 50, 20, 20));
            set_desc(2, mk(200 + i, 60, 100, 100));
            @(negedge clk);
            exp_ack = ack_q.pop_front();
            n_checks++;
            if (bus.ack_o !== exp_ack) $display("FAIL rr_ack[%0d]: got %b want %b", i, bus.ack_o, exp_ack);
            else n_pass++;
            n_checks++;
            if ({p1, p2, st} !== committed) $display("FAIL rr_live_hold[%0d]: got %h want %h", i, {p1, p2, st}, committed);
            else n_pass++;
            $display("txn rr cycle %0d: ack=%b", i, bus.ack_o);
            tick_cyc();
        end
        bus.req_i = '0;
        exp_shadow[0] = mk(30, 20, 30, 40);
        exp_shadow[1] = mk(101, 50, 20, 20);
        exp_shadow[2] = mk(202, 60, 100, 100);
        live_q.push_back(shadow_snapshot());
        @(negedge clk);
        n_checks++;
        if (dirty !== 3'b111) $display("FAIL rr_dirty: got %b want 111", dirty);
        else n_pass++;
        tick_cyc();
        do_frame();
        @(negedge clk);
        exp_live = live_q.pop_front();
        n_checks++;
        if ({p1, p2, st} !== exp_live) $display("FAIL rr_commit: got %h want %h", {p1, p2, st}, exp_live);
        else n_pass++;
        committed = exp_live;
        n_checks++;
        if (dirty !== 3'b000) $display("FAIL rr_dirty_clear: got %b want 000", dirty);
        else n_pass++;
        n_checks++;
        if (fcnt !== 16'd2) $display("FAIL rr_fcnt: got %0d want 2", fcnt);
        else n_pass++;
        tick_cyc();
    endtask

    task automatic test_validity();
        int          slots [5] = '{0, 0, 0, 1, 2};
        logic [63:0] descs [5];
        bit          oks   [5] = '{1, 0, 0, 1, 0};
        live_t       exp_live;
        descs[0] = mk(600, 0, 40, 10);
        descs[1] = mk(601, 0, 40, 10);
        descs[2] = mk(16'hFFFF, 0, 1, 1);
        descs[3] = mk(0, 470, 20, 10);
        descs[4] = mk(5, 5, 0, 5);
        for (int i = 0; i < 5; i++) begin
            set_desc(slots[i], descs[i]);
            bus.req_i = 3'(1 << slots[i]);
            ack_q.push_back(3'(1 << slots[i]));
            if (oks[i]) exp_shadow[slots[i]] = descs[i];
            @(negedge clk);
            n_checks++;
            if (bus.ack_o !== ack_q[0]) $display("FAIL valid_ack[%0d]: got %b want %b", i, bus.ack_o, ack_q[0]);
            else n_pass++;
            void'(ack_q.pop_front());
            $display("txn validity %0d: slot %0d desc %h", i, slots[i], descs[i]);
            tick_cyc();
        end
        bus.req_i = '0;
        @(negedge clk);
        n_checks++;
        if (err !== 3'b101) $display("FAIL valid_err: got %b want 101", err);
        else n_pass++;
        live_q.push_back(shadow_snapshot());
        tick_cyc();
        do_frame();
        @(negedge clk);
        exp_live = live_q.pop_front();
        n_checks++;
        if ({p1, p2, st} !== exp_live) $display("FAIL valid_commit: got %h want %h", {p1, p2, st}, exp_live);
        else n_pass++;
        committed = exp_live;
        n_checks++;
        if (p1[63:48] !== 16'd600) $display("FAIL valid_p1_x: got %0d want 600", p1[63:48]);
        else n_pass++;
        n_checks++;
        if (err !== 3'b101) $display("FAIL valid_err_sticky: got %b want 101", err);
        else n_pass++;
        tick_cyc();
    endtask

    task automatic test_edge_request();
        live_t exp_live;
        vs = 1'b0;
        set_desc(1, mk(300, 300, 50, 50));
        bus.req_i = 3'b010;
        exp_shadow[1] = mk(300, 300, 50, 50);
        live_q.push_back(shadow_snapshot());
        @(negedge clk);
        n_checks++;
        if (bus.ack_o !== 3'b010) $display("FAIL edge_ack: got %b want 010", bus.ack_o);
        else n_pass++;
        tick_cyc();
        bus.req_i = '0;
        @(negedge clk);
        n_checks++;
        if (tick !== 1'b1) $display("FAIL edge_tick: got %b want 1", tick);
        else n_pass++;
        tick_cyc();
        vs = 1'b1;
        @(negedge clk);
        exp_live = live_q.pop_front();
        n_checks++;
        if ({p1, p2, st} !== exp_live) $display("FAIL edge_commit: got %h want %h", {p1, p2, st}, exp_live);
        else n_pass++;
        committed = exp_live;
        $display("txn edge request: p2=%h", p2);
        tick_cyc();
    endtask

    task automatic test_commit_request();
        live_t exp_live;
        vs = 1'b0;
        tick_cyc();
        set_desc(2, mk(400, 100, 200, 300));
        bus.req_i = 3'b100;
        @(negedge clk);
        n_checks++;
        if (tick !== 1'b1) $display("FAIL commitreq_tick: got %b want 1", tick);
        else n_pass++;
        n_checks++;
        if (bus.ack_o !== 3'b000) $display("FAIL commitreq_ack_in_commit: got %b want 000", bus.ack_o);
        else n_pass++;
        tick_cyc();
        vs = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ack_o !== 3'b100) $display("FAIL commitreq_ack_next: got %b want 100", bus.ack_o);
        else n_pass++;
        exp_shadow[2] = mk(400, 100, 200, 300);
        tick_cyc();
        bus.req_i = '0;
        @(negedge clk);
        n_checks++;
        if (st !== committed.st) $display("FAIL commitreq_hold: got %h want %h", st, committed.st);
        else n_pass++;
        live_q.push_back(shadow_snapshot());
        tick_cyc();
        do_frame();
        @(negedge clk);
        exp_live = live_q.pop_front();
        n_checks++;
        if ({p1, p2, st} !== exp_live) $display("FAIL commitreq_commit: got %h want %h", {p1, p2, st}, exp_live);
        else n_pass++;
        committed = exp_live;
        $display("txn commit request: stage=%h", st);
        tick_cyc();
    endtask

    task automatic test_back_to_back();
        live_t exp_live;
        bus.req_i = 3'b001;
        set_desc(0, mk(1, 2, 3, 4));
        @(negedge clk);
        n_checks++;
        if (bus.ack_o !== 3'b001) $display("FAIL b2b_ack0: got %b want 001", bus.ack_o);
        else n_pass++;
        tick_cyc();
        set_desc(0, mk(5, 6, 7, 8));
        @(negedge clk);
        n_checks++;
        if (bus.ack_o !== 3'b001) $display("FAIL b2b_ack1: got %b want 001", bus.ack_o);
        else n_pass++;
        tick_cyc();
        bus.req_i = '0;
        exp_shadow[0] = mk(5, 6, 7, 8);
        live_q.push_back(shadow_snapshot());
        do_frame();
        @(negedge clk);
        exp_live = live_q.pop_front();
        n_checks++;
        if ({p1, p2, st} !== exp_live) $display("FAIL b2b_commit: got %h want %h", {p1, p2, st}, exp_live);
        else n_pass++;
        committed = exp_live;
        $display("txn back-to-back: p1=%h", p1);
        tick_cyc();
    endtask

    task automatic test_async_reset();
        live_t exp_live;
        set_desc(0, mk(11, 11, 11, 11));
        set_desc(1, mk(22, 22, 22, 22));
        bus.req_i = 3'b011;
        @(negedge clk);
        n_checks++;
        if (bus.ack_o !== 3'b010) $display("FAIL arst_ack0: got %b want 010", bus.ack_o);
        else n_pass++;
        tick_cyc();
        bus.req_i = 3'b001;
        @(negedge clk);
        n_checks++;
        if (bus.ack_o !== 3'b001) $display("FAIL arst_ack1: got %b want 001", bus.ack_o);
        else n_pass++;
        tick_cyc();
        bus.req_i = '0;
        @(negedge clk);
        n_checks++;
        if (dirty !== 3'b011) $display("FAIL arst_dirty_before: got %b want 011", dirty);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({p1, p2, st} !== 192'd0) $display("FAIL arst_live: got %h want 0", {p1, p2, st});
        else n_pass++;
        n_checks++;
        if ({dirty, err, bus.ack_o, tick} !== 10'd0)
            $display("FAIL arst_flags: dirty=%b err=%b ack=%b tick=%b want all 0", dirty, err, bus.ack_o, tick);
        else n_pass++;
        n_checks++;
        if (fcnt !== 16'd0) $display("FAIL arst_fcnt: got %0d want 0", fcnt);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 3; s++) exp_shadow[s] = '0;
        live_q.push_back(shadow_snapshot());
        tick_cyc();
        do_frame();
        @(negedge clk);
        exp_live = live_q.pop_front();
        n_checks++;
        if ({p1, p2, st} !== exp_live) $display("FAIL arst_commit: got %h want %h", {p1, p2, st}, exp_live);
        else n_pass++;
        committed = exp_live;
        n_checks++;
        if (fcnt !== 16'd1) $display("FAIL arst_fcnt_after: got %0d want 1", fcnt);
        else n_pass++;
        $display("txn async reset: frame_cnt=%0d", fcnt);
        tick_cyc();
    endtask

    task automatic test_wrap();
        repeat (14) do_frame();
        @(negedge clk);
        n_checks++;
        if (fcnt_s !== 4'd15) $display("FAIL wrap_pre: got %0d want 15", fcnt_s);
        else n_pass++;
        tick_cyc();
        do_frame();
        @(negedge clk);
        n_checks++;
        if (fcnt_s !== 4'd0) $display("FAIL wrap_zero: got %0d want 0", fcnt_s);
        else n_pass++;
        n_checks++;
        if (fcnt !== 16'd16) $display("FAIL wrap_wide: got %0d want 16", fcnt);
        else n_pass++;
        $display("txn wrap: small=%0d wide=%0d", fcnt_s, fcnt);
        tick_cyc();
    endtask

    initial begin
        bus_s.req_i  = '0;
        bus_s.desc_i = '0;
        for (int s = 0; s < 3; s++) exp_shadow[s] = '0;
        committed = '0;
        test_reset();
        test_round_robin();
        test_validity();
        test_edge_request();
        test_commit_request();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
